// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for seq_restoring_divider.
// The controller uses the master modport and the divider uses the slave modport.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );

endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider that produces one quotient bit per clock.
// A division starts when start is seen in IDLE. The block then runs WIDTH
// iterations and pulses done for one cycle, with the results already registered.
// The quotient and remainder outputs change only when an operation completes.
// Optional macro DIV_ZERO_CHECK_EN: a zero divisor skips the iterations, the
// result is returned on the next edge and the dz flag is raised.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH:0]   a, a_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] m, m_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic [WIDTH-1:0] quo_q, quo_n;
  logic [WIDTH-1:0] rem_q, rem_n;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   a_it;
  logic [WIDTH-1:0] q_it;

`ifdef DIV_ZERO_CHECK_EN
  logic             dz_q, dz_n;
`endif

  // One restoring step: shift {A,Q} left by one, trial-subtract M, then restore A on borrow
  always_comb begin
    a_sh = (a << 1) | (WIDTH + 1)'(q[WIDTH-1]);
    t    = a_sh - {1'b0, m};
    a_it = t[WIDTH] ? a_sh : t;
    q_it = {q[WIDTH-2:0], ~t[WIDTH]};
  end

  // Next-state logic and datapath/output updates
  always_comb begin
    state_n = state;
    a_n     = a;
    q_n     = q;
    m_n     = m;
    cnt_n   = cnt;
    busy_n  = busy_q;
    done_n  = 1'b0;
    quo_n   = quo_q;
    rem_n   = rem_q;
`ifdef DIV_ZERO_CHECK_EN
    dz_n    = dz_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          m_n    = bus.divisor;
          q_n    = bus.dividend;
          a_n    = '0;
          cnt_n  = CNT_W'(WIDTH);
          busy_n = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
          state_n = (bus.divisor == '0) ? ZERO : RUN;
`else
          state_n = RUN;
`endif
        end
      end
      RUN: begin
        a_n   = a_it;
        q_n   = q_it;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          quo_n   = q_it;
          rem_n   = a_it[WIDTH-1:0];
`ifdef DIV_ZERO_CHECK_EN
          dz_n    = 1'b0;
`endif
        end
      end
`ifdef DIV_ZERO_CHECK_EN
      ZERO: begin
        // Q still holds the dividend that was latched at load
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        quo_n   = '1;
        rem_n   = q;
        dz_n    = 1'b1;
      end
`endif
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a      <= '0;
      q      <= '0;
      m      <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      a      <= a_n;
      q      <= q_n;
      m      <= m_n;
      cnt    <= cnt_n;
      busy_q <= busy_n;
      done_q <= done_n;
      quo_q  <= quo_n;
      rem_q  <= rem_n;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  // Divide-by-zero flag holds until the next completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= dz_n;
    end
  end

  assign bus.dz = dz_q;
`else
  assign bus.dz = 1'b0;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider with WIDTH=4.
module tb_seq_restoring_divider;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst_n;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] last_r;

  seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present the operands with start for one edge, then scramble the operands
  task automatic issue(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    tick();
    bus.start    = 1'b0;
    bus.dividend = WIDTH'($urandom);
    bus.divisor  = WIDTH'($urandom);
  endtask

  // Called one step after the load edge. Waits for done, checking that the
  // previous result stays visible meanwhile, then checks latency and result.
  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                           input logic edz);
    int lat;
    int busy_cnt;
    bit hold_ok;
    lat      = 0;
    busy_cnt = 0;
    hold_ok  = 1'b1;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busy_cnt++;
      if (bus.quotient !== last_q || bus.remainder !== last_r) hold_ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_hold"}, int'(hold_ok), 1);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_quotient"}, bus.quotient, eq);
    check({tag, "_remainder"}, bus.remainder, er);
    check({tag, "_dz"}, bus.dz, edz);
    last_q = eq;
    last_r = er;
  endtask

  task automatic run(input string tag, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                     input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
    issue(dvd, dvs);
    check({tag, "_busy_after_load"}, bus.busy, 1);
    wait_done(tag, WIDTH, eq, er, 1'b0);
    tick();
    check({tag, "_done_one_cycle"}, bus.done, 0);
  endtask

  initial begin
    int extra_done;
    n_checks     = 0;
    n_pass       = 0;
    last_q       = '0;
    last_r       = '0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dz", bus.dz, 0);
    rst_n = 1'b1;
    tick();

    run("d8_4", 4'd8, 4'd4, 4'd2, 4'd0);
    run("d15_4", 4'd15, 4'd4, 4'd3, 4'd3);
    run("d7_9", 4'd7, 4'd9, 4'd0, 4'd7);
    run("d15_1", 4'd15, 4'd1, 4'd15, 4'd0);

    // Hold start high and change the operands while busy; only the first operands count
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    tick();
    bus.dividend = 4'd2;
    bus.divisor  = 4'd1;
    wait_done("held_start", WIDTH, 4'd4, 4'd1, 1'b0);
    bus.start = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done) extra_done++;
    end
    check("held_start_no_second_done", extra_done, 0);
    check("held_start_idle", bus.busy, 0);

    // Back-to-back: start a new operation on the cycle that done is high
    issue(4'd8, 4'd4);
    wait_done("b2b_first", WIDTH, 4'd2, 4'd0, 1'b0);
    issue(4'd9, 4'd2);
    check("b2b_busy_after_load", bus.busy, 1);
    wait_done("b2b_second", WIDTH, 4'd4, 4'd1, 1'b0);
    tick();

    // Reset asserted at the second iteration edge aborts the operation
    issue(4'd14, 4'd5);
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done || bus.busy) extra_done++;
    end
    check("abort_stays_idle", extra_done, 0);
    last_q = '0;
    last_r = '0;
    run("d14_5", 4'd14, 4'd5, 4'd2, 4'd4);

    // Divide by zero
    issue(4'd11, 4'd0);
`ifdef DIV_ZERO_CHECK_EN
    wait_done("dz11_0", 1, 4'd15, 4'd11, 1'b1);
`else
    wait_done("dz11_0", WIDTH, 4'd15, 4'd11, 1'b0);
`endif
    tick();
    check("dz11_0_done_one_cycle", bus.done, 0);
`ifdef DIV_ZERO_CHECK_EN
    check("dz11_0_dz_held", bus.dz, 1);
`else
    check("dz11_0_dz_held", bus.dz, 0);
`endif
    run("d6_3", 4'd6, 4'd3, 4'd2, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
